unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbitrates one single-ported, fixed-latency unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the five-stage pipeline. It accepts one access at a time, sequences it through issue/wait/complete states, and returns read data with a one-cycle valid pulse. It also produces per-port stall signals that the pipeline uses to gate PCWrite, IF_IDwrite and the downstream pipeline registers. A starvation counter keeps a burst of data accesses from locking out instruction fetch.

## Interface
- MEM_LAT, 2: memory read latency in cycles, ≥1; mem_rdata is valid MEM_LAT cycles after the mem_en cycle.
- STARVE_MAX, 4: consecutive data-port grants with if_req pending before IF is forced to win; range 1..15.
- clock  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction, registered.
- if_valid  out  1  one-cycle pulse: the fetch is complete and if_rdata is valid.
- if_stall  out  1  if_req & ~if_valid; combinational.
- dm_req  in  1  data request; held until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data, registered.
- dm_valid  out  1  one-cycle pulse: the load or store is complete.
- dm_stall  out  1  dm_req & ~dm_valid; combinational.
- mem_en  out  1  memory access strobe; high for exactly one cycle per access.
- mem_we  out  1  write enable; qualified by mem_en.
- mem_addr  out  32  latched access address.
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  memory read data.
- busy  out  1  1 whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. State, grant side, counters and the rdata registers are all flopped.
- IDLE, no request: remain in IDLE.
- IDLE, request present: choose a winner.
  - Only one port requesting: that port wins.
  - Both ports requesting: DM wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- Grant action: latch the winner's address, dm_we and dm_wdata into the mem_* registers (IF grant forces mem_we=0). Store the grant side and go to ISSUE.
- ISSUE: mem_en=1. Load wait_cnt = MEM_LAT-1 and go to WAIT.
- WAIT:
  - wait_cnt ≠ 0: decrement wait_cnt.
  - wait_cnt == 0: for a read, capture mem_rdata into the granted side's rdata register; go to DONE.
- DONE: pulse the granted side's valid for one cycle, then return to IDLE. A new grant can be made the cycle after DONE.
- Stores: the write is performed by the memory in the ISSUE cycle. dm_valid still pulses in DONE, and dm_rdata keeps its previous value.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, on each DM grant made while if_req=1.
  - Clears on any IF grant.
  - Unchanged on a DM grant made while if_req=0.
- Requester drops req mid-access (flush): the access still completes, including any write, and valid still pulses; the requester ignores it.
- mem_addr is passed through as a full byte address; word selection is done by the memory.

## Timing
- Reset values: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_valid=0, dm_valid=0, busy=0, starve_cnt=0, wait_cnt=0.
- rst asserted mid-access:
  - Return to IDLE immediately; no valid pulse is produced.
  - The abandoned memory response is ignored.
  - A store that already reached ISSUE may have completed in memory.
- Request latency, counted from the cycle req is seen in IDLE (cycle 0):
  - ISSUE = cycle 1.
  - WAIT = cycles 2..1+MEM_LAT.
  - valid = cycle 2+MEM_LAT (4 cycles at MEM_LAT=2).
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Stall outputs are combinational from req and the registered valid, so there is no extra cycle of stall.
- mem_rdata is sampled at the rising edge that ends the last WAIT cycle.

## Test plan
- Single fetch, MEM_LAT=2, if_addr=0x8, memory returns 0x01095024:
  - mem_en high in cycle 1 only, with mem_addr=0x8.
  - if_valid in cycle 4, if_rdata=0x01095024.
  - if_stall high in cycles 0–3 and low in cycle 4.
- Store then load to 0x4:
  - dm_we=1, dm_wdata=0x37: mem_we=1 with mem_en; dm_valid at +4; dm_rdata unchanged.
  - Following load to 0x4 returns 0x37.
- Simultaneous if_req and dm_req from IDLE: DM is granted first; IF is granted the cycle after dm_valid; if_valid arrives 9 cycles after the start.
- Starvation, STARVE_MAX=4: if_req held while dm_req is re-asserted continuously. Exactly 4 DM grants occur, then an IF grant, then starve_cnt=0.
- rst pulsed in WAIT of a load:
  - All outputs return to reset values asynchronously.
  - No dm_valid pulse.
  - The next request after reset completes normally.
- MEM_LAT=1: valid arrives in cycle 3; WAIT lasts exactly one cycle.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported, fixed-latency memory between the instruction-fetch
// port and the data port. One access is in flight at a time. It is sequenced
// IDLE -> ISSUE -> WAIT -> DONE, and DONE raises a one-cycle valid pulse on the
// granted side. The data port wins ties, except when a starvation counter
// shows that fetch has lost STARVE_MAX ties in a row.
module unified_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        rst,
  // instruction-fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  // memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  // wait_cnt only has to hold MEM_LAT-1
  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic          grant_dm;    // 1: the access in flight belongs to the data port
  logic [3:0]    starve_cnt;  // consecutive data grants won while fetch was waiting
  logic [WW-1:0] wait_cnt;
  logic          pick_dm;

  // Data port wins unless it is absent or fetch has been starved long enough
  assign pick_dm  = dm_req & ~(if_req & (starve_cnt == 4'(STARVE_MAX)));

  // Stalls come straight from req and the registered valid: no extra stall cycle
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;
  assign busy     = (state != IDLE);

  // Access sequencer: arbitration, memory strobe, latency count, read capture, valid pulse
  // NOTE: every register here uses non-blocking assignment so all of them see the
  // pre-edge values of each other; a blocking assignment would create ordering races.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_dm   <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state    <= ISSUE;
            mem_en   <= 1'b1;
            grant_dm <= pick_dm;
            if (pick_dm) begin
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
              // Only a grant taken away from a waiting fetch counts toward starvation
              if (if_req && (starve_cnt != 4'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
              mem_addr   <= if_addr;
              mem_we     <= 1'b0;
              starve_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          // The strobe is high for this cycle only; a store is committed here
          mem_en   <= 1'b0;
          wait_cnt <= WW'(MEM_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            // mem_rdata is valid in this last WAIT cycle
            if (grant_dm) begin
              if (!mem_we) dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
// Directed plus randomized bench. dut0 runs at MEM_LAT=2 and dut1 at MEM_LAT=1.
// Each DUT has a fixed-latency memory model behind it. Random traffic is
// predicted by a transaction-level model: the arbitration rule, a shadow
// memory and the nominal per-access latencies.
module tb_unified_mem_arbiter;

  localparam int L0 = 2;
  localparam int SM = 4;

  logic clock;
  logic rst;

  // dut0 (MEM_LAT=2)
  logic        if_req0, if_valid0, if_stall0, dm_req0, dm_we0, dm_valid0, dm_stall0;
  logic        mem_en0, mem_we0, busy0;
  logic [31:0] if_addr0, if_rdata0, dm_addr0, dm_wdata0, dm_rdata0;
  logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;
  // dut1 (MEM_LAT=1)
  logic        if_req1, if_valid1, if_stall1, dm_req1, dm_we1, dm_valid1, dm_stall1;
  logic        mem_en1, mem_we1, busy1;
  logic [31:0] if_addr1, if_rdata1, dm_addr1, dm_wdata1, dm_rdata1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  int errors = 0;
  int checks = 0;

  unified_mem_arbiter #(.MEM_LAT(L0), .STARVE_MAX(SM)) dut0 (
    .clock(clock), .rst(rst),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_valid(if_valid0), .if_stall(if_stall0),
    .dm_req(dm_req0), .dm_we(dm_we0), .dm_addr(dm_addr0), .dm_wdata(dm_wdata0),
    .dm_rdata(dm_rdata0), .dm_valid(dm_valid0), .dm_stall(dm_stall0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  unified_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SM)) dut1 (
    .clock(clock), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1), .if_stall(if_stall1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_valid(dm_valid1), .dm_stall(dm_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Power-on memory contents; word 2 (byte 0x8) holds the test instruction
  function automatic logic [31:0] init_val(input int w);
    if (w == 2) return 32'h0109_5024;
    return 32'h5a5a_0000 ^ (32'(w) * 32'h0001_0203);
  endfunction

  // Memory model for dut0: writes on the strobe, read data appears L0 cycles later
  logic [31:0] m0 [0:63];
  bit   [63:0] wr0;
  logic [31:0] p0_d [0:1];
  logic        p0_v [0:1];
  always @(posedge clock) begin
    if (mem_en0 && mem_we0) begin
      m0[mem_addr0[7:2]]  <= mem_wdata0;
      wr0[mem_addr0[7:2]] <= 1'b1;
    end
    p0_d[0] <= wr0[mem_addr0[7:2]] ? m0[mem_addr0[7:2]] : init_val(int'(mem_addr0[7:2]));
    p0_v[0] <= mem_en0 && !mem_we0;
    p0_d[1] <= p0_d[0];
    p0_v[1] <= p0_v[0];
  end
  assign mem_rdata0 = p0_v[1] ? p0_d[1] : 32'hBAD0_BAD0;

  // Memory model for dut1 (read-only): data one cycle after the strobe
  logic [31:0] p1_d;
  logic        p1_v;
  always @(posedge clock) begin
    p1_d <= init_val(int'(mem_addr1[7:2]));
    p1_v <= mem_en1 && !mem_we1;
  end
  assign mem_rdata1 = p1_v ? p1_d : 32'hBAD1_BAD1;

  // Reference model state (transaction level)
  logic [31:0] ref_mem [0:63];
  bit   [63:0] ref_wr;
  logic [31:0] ref_dm_rdata;
  int          ref_starve;

  function automatic logic [31:0] ref_read(input int w);
    return ref_wr[w] ? ref_mem[w] : init_val(w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a valid pulse on dut0; cyc = -1 when the bound expires
  task automatic wait_valid0(input bit is_dm, input int start, output int cyc);
    cyc = -1;
    for (int c = start; c < start + 40; c++) begin
      @(negedge clock);
      if ((is_dm ? dm_valid0 : if_valid0) === 1'b1) begin
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  // Random-section variables
  int          kind, ia, da, cyc, exp_if_cyc, exp_dm_cyc, n_grants;
  bit          use_if, use_dm, dm_first, rwe, done_if, done_dm, seen;
  logic [31:0] rwd, exp_if, exp_dm;
  bit          grant_is_if [0:7];

  task automatic model_dm();
    if (rwe) begin
      ref_mem[da] = rwd;
      ref_wr[da]  = 1'b1;
      exp_dm      = ref_dm_rdata;
    end else begin
      exp_dm       = ref_read(da);
      ref_dm_rdata = exp_dm;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {if_req0, dm_req0, dm_we0, if_req1, dm_req1, dm_we1} = '0;
    {if_addr0, dm_addr0, dm_wdata0, if_addr1, dm_addr1, dm_wdata1} = '0;
    ref_wr = '0;
    ref_starve = 0;
    repeat (3) @(posedge clock);

    // ---- reset state
    @(negedge clock);
    check("rst mem_en", 32'(mem_en0), 0);
    check("rst mem_we", 32'(mem_we0), 0);
    check("rst mem_addr", mem_addr0, 0);
    check("rst busy", 32'(busy0), 0);
    check("rst valids", {30'd0, if_valid0, dm_valid0}, 0);
    check("rst rdata", if_rdata0 | dm_rdata0, 0);
    @(posedge clock);
    #1 rst = 1'b0;
    tick();

    // ---- single fetch from 0x8
    if_req0 = 1'b1;
    if_addr0 = 32'h8;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clock);
      check($sformatf("fetch mem_en c%0d", c), 32'(mem_en0), 32'(c == 1));
      check($sformatf("fetch if_stall c%0d", c), 32'(if_stall0), 32'(c < 4));
      check($sformatf("fetch if_valid c%0d", c), 32'(if_valid0), 32'(c == 4));
      if (c == 1) check("fetch mem_addr", mem_addr0, 32'h8);
      if (c == 4) check("fetch if_rdata", if_rdata0, 32'h0109_5024);
      tick();
    end
    if_req0 = 1'b0;
    tick();

    // ---- store 0x37 to 0x4
    dm_req0 = 1'b1; dm_we0 = 1'b1; dm_addr0 = 32'h4; dm_wdata0 = 32'h37;
    tick();
    @(negedge clock);
    check("store mem_en", 32'(mem_en0), 1);
    check("store mem_we", 32'(mem_we0), 1);
    check("store mem_addr", mem_addr0, 32'h4);
    check("store mem_wdata", mem_wdata0, 32'h37);
    tick();
    wait_valid0(1'b1, 2, cyc);
    check("store latency", 32'(cyc), 4);
    check("store dm_rdata kept", dm_rdata0, 0);
    tick();
    dm_req0 = 1'b0; dm_we0 = 1'b0;
    tick();

    // ---- load back from 0x4
    dm_req0 = 1'b1;
    wait_valid0(1'b1, 0, cyc);
    check("load latency", 32'(cyc), 4);
    check("load dm_rdata", dm_rdata0, 32'h37);
    tick();
    dm_req0 = 1'b0;
    tick();

    // ---- simultaneous requests: data first, fetch right after
    if_req0 = 1'b1; if_addr0 = 32'h8;
    dm_req0 = 1'b1; dm_addr0 = 32'h4;
    wait_valid0(1'b1, 0, cyc);
    check("tie dm latency", 32'(cyc), 4);
    check("tie dm_rdata", dm_rdata0, 32'h37);
    tick();
    dm_req0 = 1'b0;
    wait_valid0(1'b0, 5, cyc);
    check("tie if latency", 32'(cyc), 9);
    check("tie if_rdata", if_rdata0, 32'h0109_5024);
    tick();
    if_req0 = 1'b0;
    tick();

    // ---- starvation: fetch held, data request held continuously
    if_req0 = 1'b1;
    dm_req0 = 1'b1;
    n_grants = 0;
    cyc = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (mem_en0 === 1'b1 && n_grants < 8) begin
        grant_is_if[n_grants] = (mem_addr0 == 32'h8);
        n_grants++;
      end
      if (if_valid0 === 1'b1) cyc = c;
      tick();
      if (cyc >= 0) break;
    end
    if_req0 = 1'b0;
    dm_req0 = 1'b0;
    check("starve grant count", 32'(n_grants), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("starve grant %0d is_if", i), 32'(grant_is_if[i]), 32'(i == 4));
    check("starve if latency", 32'(cyc), 24);
    check("starve cnt cleared", 32'(dut0.starve_cnt), 0);
    tick();

    // ---- reset during WAIT of a load
    dm_req0 = 1'b1; dm_addr0 = 32'h4;
    tick();
    tick();
    @(negedge clock);
    check("rst-mid busy before", 32'(busy0), 1);
    rst = 1'b1;
    dm_req0 = 1'b0;
    #1;
    check("rst-mid busy", 32'(busy0), 0);
    check("rst-mid mem_en", 32'(mem_en0), 0);
    check("rst-mid mem_addr", mem_addr0, 0);
    check("rst-mid dm_rdata", dm_rdata0, 0);
    check("rst-mid dm_valid", 32'(dm_valid0), 0);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen |= dm_valid0;
    end
    check("rst-mid no dm_valid", 32'(seen), 0);
    dm_req0 = 1'b1;
    wait_valid0(1'b1, 0, cyc);
    check("post-rst load latency", 32'(cyc), 4);
    check("post-rst load data", dm_rdata0, 32'h37);
    tick();
    dm_req0 = 1'b0;
    tick();

    // ---- MEM_LAT=1 fetch on dut1
    if_req1 = 1'b1; if_addr1 = 32'h10;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clock);
      check($sformatf("lat1 mem_en c%0d", c), 32'(mem_en1), 32'(c == 1));
      check($sformatf("lat1 busy c%0d", c), 32'(busy1), 32'(c >= 1));
      check($sformatf("lat1 if_valid c%0d", c), 32'(if_valid1), 32'(c == 3));
      if (c == 3) check("lat1 if_rdata", if_rdata1, init_val(4));
      tick();
    end
    if_req1 = 1'b0;
    tick();

    // ---- randomized traffic on dut0 against the transaction model
    // ref_dm_rdata tracks the data port's last load (0x37 from the step above);
    // ref_starve is 0 because the reset cleared it and later grants were data-only.
    ref_dm_rdata = 32'h37;
    ref_starve = 0;
    for (int it = 0; it < 40; it++) begin
      kind   = $urandom_range(0, 5);
      use_if = (kind == 0) || (kind >= 2);
      use_dm = (kind >= 1);
      ia  = $urandom_range(16, 23);
      da  = $urandom_range(16, 23);
      rwe = 1'($urandom_range(0, 1));
      rwd = $urandom;
      dm_first = use_dm && !(use_if && ref_starve == SM);
      exp_if = 'x; exp_dm = 'x; exp_if_cyc = -1; exp_dm_cyc = -1;
      if (dm_first) begin
        if (use_if) ref_starve = (ref_starve < SM) ? ref_starve + 1 : SM;
        model_dm();
        exp_dm_cyc = 2 + L0;
        if (use_if) begin
          ref_starve = 0;
          exp_if = ref_read(ia);
          exp_if_cyc = 2 + L0 + (L0 + 3);
        end
      end else begin
        if (use_if) begin
          ref_starve = 0;
          exp_if = ref_read(ia);
          exp_if_cyc = 2 + L0;
        end
        if (use_dm) begin
          model_dm();
          exp_dm_cyc = use_if ? 2 + L0 + (L0 + 3) : 2 + L0;
        end
      end

      tick();
      if_req0 = use_if; if_addr0 = 32'(ia) << 2;
      dm_req0 = use_dm; dm_we0 = rwe; dm_addr0 = 32'(da) << 2; dm_wdata0 = rwd;
      done_if = !use_if;
      done_dm = !use_dm;
      for (int c = 0; c < 30 && !(done_if && done_dm); c++) begin
        @(negedge clock);
        if (if_valid0 === 1'b1 && !done_if) begin
          check($sformatf("rnd%0d if cycle", it), 32'(c), 32'(exp_if_cyc));
          check($sformatf("rnd%0d if_rdata", it), if_rdata0, exp_if);
          done_if = 1'b1;
        end
        if (dm_valid0 === 1'b1 && !done_dm) begin
          check($sformatf("rnd%0d dm cycle", it), 32'(c), 32'(exp_dm_cyc));
          check($sformatf("rnd%0d dm_rdata", it), dm_rdata0, exp_dm);
          done_dm = 1'b1;
        end
        tick();
        if (done_if) if_req0 = 1'b0;
        if (done_dm) dm_req0 = 1'b0;
      end
      check($sformatf("rnd%0d all served", it), {30'd0, done_if, done_dm}, 32'd3);
      if_req0 = 1'b0;
      dm_req0 = 1'b0;
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
